// File: rtl/router_out_deser.sv
// Deserialises the four serial router output ports into words and merges them round-robin
// onto one valid/ready stream. Define ROUTER_DESER_STATS_EN to add per-port accepted-word counters.
module router_out_deser #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 8,
    parameter int PORT_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_PORTS-1:0]     rx_valid,
    input  logic [N_PORTS-1:0]     rx_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic [PORT_W-1:0]      m_port,
`ifdef ROUTER_DESER_STATS_EN
    output logic [N_PORTS*16-1:0]  stat_words,
`endif
    output logic [N_PORTS-1:0]     frag_err,
    output logic [N_PORTS-1:0]     ovf_sticky
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sreg     [N_PORTS];
    logic [CNT_W-1:0]  cnt      [N_PORTS];
    logic [DATA_W-1:0] hold     [N_PORTS];
    logic [DATA_W-1:0] word_new [N_PORTS];
    logic [N_PORTS-1:0] hold_full;
    logic [N_PORTS-1:0] drain;
    logic [PORT_W-1:0]  rr_ptr;
    logic [PORT_W-1:0]  pick_idx;
    logic               pick_vld;
    logic               loadable;

    // The completing word is the stored low bits plus the bit arriving this cycle.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            word_new[i]             = sreg[i];
            word_new[i][DATA_W-1]   = rx_data[i];
        end
    end

    assign loadable = !m_valid || m_ready;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        logic [PORT_W-1:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = PORT_W'((int'(rr_ptr) + k) % N_PORTS);
            if (!pick_vld && hold_full[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        drain = '0;
        if (loadable && pick_vld) drain[pick_idx] = 1'b1;
    end

    // NOTE: the data arrays are reset too, so a reset leaves no stale word that could
    // leak out later; sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PORTS; i++) begin
                sreg[i] <= '0;
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
            hold_full  <= '0;
            frag_err   <= '0;
            ovf_sticky <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                frag_err[i] <= 1'b0;
                if (drain[i]) hold_full[i] <= 1'b0;
                if (rx_valid[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        cnt[i] <= '0;
                        // A drain in the same cycle frees the slot for the new word.
                        if (!hold_full[i] || drain[i]) begin
                            hold[i]      <= word_new[i];
                            hold_full[i] <= 1'b1;
                        end else begin
                            ovf_sticky[i] <= 1'b1;
                        end
                    end else begin
                        sreg[i][cnt[i]] <= rx_data[i];
                        cnt[i]          <= cnt[i] + 1'b1;
                    end
                end else if (cnt[i] != '0) begin
                    cnt[i]      <= '0;
                    frag_err[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_port  <= '0;
            rr_ptr  <= '0;
        end else if (loadable) begin
            if (pick_vld) begin
                m_valid <= 1'b1;
                m_data  <= hold[pick_idx];
                m_port  <= pick_idx;
                rr_ptr  <= (pick_idx == PORT_W'(N_PORTS - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef ROUTER_DESER_STATS_EN
    logic [15:0] stat_cnt [N_PORTS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PORTS; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (m_valid && m_ready && m_port == PORT_W'(i) && stat_cnt[i] != 16'hFFFF)
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < N_PORTS; i++) stat_words[i*16 +: 16] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_router_out_deser.sv
// Directed bench for router_out_deser: reset, single word, fragment, round-robin,
// same-cycle drain/load, back-pressure with overflow, and optional stats counters.
module tb_router_out_deser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  rx_valid;
    logic [3:0]  rx_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_port;
    logic [3:0]  frag_err;
    logic [3:0]  ovf_sticky;
`ifdef ROUTER_DESER_STATS_EN
    logic [63:0] stat_words;
`endif

    int checks   = 0;
    int failures = 0;

    router_out_deser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_port     (m_port),
`ifdef ROUTER_DESER_STATS_EN
        .stat_words (stat_words),
`endif
        .frag_err   (frag_err),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word per port in mask, LSB first, over DATA_W consecutive cycles.
    task automatic send_words(input logic [3:0] mask, input logic [3:0][7:0] w);
        for (int b = 0; b < 8; b++) begin
            rx_valid = mask;
            for (int p = 0; p < 4; p++) rx_data[p] = w[p][b];
            tick();
        end
        rx_valid = '0;
        rx_data  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = '0;
        rx_data  = '0;
        m_ready  = 1'b0;
        tick();
        tick();
        if ({m_valid, m_data, m_port, frag_err, ovf_sticky} !== 19'd0) begin
            $display("FAIL reset_values got=%h exp=0", {m_valid, m_data, m_port, frag_err, ovf_sticky});
            failures++;
        end
        checks++;
        reset_n = 1'b1;
        tick();
        // Park a word in the output register, then start a partial word on port 0.
        send_words(4'b0010, {8'h00, 8'h00, 8'h55, 8'h00});
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'h55 || m_port !== 2'd1) begin
            $display("FAIL reset_preload got=%b/%h/%0d exp=1/55/1", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        for (int b = 0; b < 5; b++) begin
            rx_valid = 4'b0001;
            rx_data  = {3'b000, b[0]};
            tick();
        end
        #2 reset_n = 1'b0;
        #1;
        if ({m_valid, m_data, m_port, frag_err, ovf_sticky} !== 19'd0) begin
            $display("FAIL reset_async got=%h exp=0", {m_valid, m_data, m_port, frag_err, ovf_sticky});
            failures++;
        end
        checks++;
        rx_valid = '0;
        rx_data  = '0;
        tick();
        reset_n = 1'b1;
        m_ready = 1'b1;
        tick();
        if (frag_err !== 4'b0000 || m_valid !== 1'b0) begin
            $display("FAIL reset_no_frag got=%b/%b exp=0000/0", frag_err, m_valid);
            failures++;
        end
        checks++;
        send_words(4'b0001, {8'h00, 8'h00, 8'h00, 8'h3C});
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'h3C || m_port !== 2'd0) begin
            $display("FAIL reset_next_word got=%b/%h/%0d exp=1/3c/0", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
    endtask

    task automatic test_single_word();
        m_ready = 1'b1;
        send_words(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        if (m_valid !== 1'b0) begin
            $display("FAIL single_early got=%b exp=0", m_valid);
            failures++;
        end
        checks++;
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_port !== 2'd2) begin
            $display("FAIL single_word got=%b/%h/%0d exp=1/a5/2", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
        if (m_valid !== 1'b0) begin
            $display("FAIL single_one_cycle got=%b exp=0", m_valid);
            failures++;
        end
        checks++;
    endtask

    task automatic test_fragment();
        m_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rx_valid = 4'b0010;
            rx_data  = 4'b0010;
            tick();
        end
        rx_valid = '0;
        rx_data  = '0;
        tick();
        if (frag_err !== 4'b0010 || m_valid !== 1'b0) begin
            $display("FAIL frag_pulse got=%b/%b exp=0010/0", frag_err, m_valid);
            failures++;
        end
        checks++;
        tick();
        if (frag_err !== 4'b0000) begin
            $display("FAIL frag_one_cycle got=%b exp=0000", frag_err);
            failures++;
        end
        checks++;
        send_words(4'b0010, {8'h00, 8'h00, 8'h0F, 8'h00});
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'h0F || m_port !== 2'd1) begin
            $display("FAIL frag_next_word got=%b/%h/%0d exp=1/0f/1", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_port [3];
        logic [7:0] exp_data [3];
        do_reset();
        m_ready = 1'b1;
        send_words(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        for (int p = 0; p < 4; p++) begin
            tick();
            if (m_valid !== 1'b1 || m_port !== 2'(p) || m_data !== 8'(8'h10 + p)) begin
                $display("FAIL rr_batch1_%0d got=%b/%h/%0d exp=1/%h/%0d", p, m_valid, m_data, m_port, 8'(8'h10 + p), p);
                failures++;
            end
            checks++;
        end
        tick();
        if (m_valid !== 1'b0) begin
            $display("FAIL rr_batch1_end got=%b exp=0", m_valid);
            failures++;
        end
        checks++;
        // Port 1 alone moves the pointer to 2, so the next batch wraps 3,0,1.
        send_words(4'b0010, {8'h00, 8'h00, 8'h21, 8'h00});
        tick();
        if (m_valid !== 1'b1 || m_port !== 2'd1 || m_data !== 8'h21) begin
            $display("FAIL rr_batch2 got=%b/%h/%0d exp=1/21/1", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
        exp_port = '{2'd3, 2'd0, 2'd1};
        exp_data = '{8'h33, 8'h30, 8'h31};
        send_words(4'b1011, {8'h33, 8'h00, 8'h31, 8'h30});
        for (int n = 0; n < 3; n++) begin
            tick();
            if (m_valid !== 1'b1 || m_port !== exp_port[n] || m_data !== exp_data[n]) begin
                $display("FAIL rr_batch3_%0d got=%b/%h/%0d exp=1/%h/%0d", n, m_valid, m_data, m_port, exp_data[n], exp_port[n]);
                failures++;
            end
            checks++;
        end
        tick();
    endtask

    task automatic test_drain_and_load();
        logic [7:0] c;
        c = 8'h43;
        m_ready = 1'b0;
        send_words(4'b0001, {8'h00, 8'h00, 8'h00, 8'h41});
        send_words(4'b0001, {8'h00, 8'h00, 8'h00, 8'h42});
        if (m_valid !== 1'b1 || m_data !== 8'h41) begin
            $display("FAIL dl_stall got=%b/%h exp=1/41", m_valid, m_data);
            failures++;
        end
        checks++;
        for (int b = 0; b < 8; b++) begin
            rx_valid = 4'b0001;
            rx_data  = {3'b000, c[b]};
            if (b == 7) m_ready = 1'b1;
            tick();
        end
        rx_valid = '0;
        rx_data  = '0;
        if (m_valid !== 1'b1 || m_data !== 8'h42 || ovf_sticky !== 4'b0000) begin
            $display("FAIL dl_same_cycle got=%b/%h/%b exp=1/42/0000", m_valid, m_data, ovf_sticky);
            failures++;
        end
        checks++;
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'h43 || m_port !== 2'd0) begin
            $display("FAIL dl_third got=%b/%h/%0d exp=1/43/0", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
        if (m_valid !== 1'b0 || ovf_sticky !== 4'b0000) begin
            $display("FAIL dl_end got=%b/%b exp=0/0000", m_valid, ovf_sticky);
            failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back_overflow();
        m_ready = 1'b0;
        send_words(4'b1000, {8'h01, 8'h00, 8'h00, 8'h00});
        send_words(4'b1000, {8'h02, 8'h00, 8'h00, 8'h00});
        send_words(4'b1000, {8'h03, 8'h00, 8'h00, 8'h00});
        if (m_valid !== 1'b1 || m_data !== 8'h01 || m_port !== 2'd3 || ovf_sticky !== 4'b1000) begin
            $display("FAIL ovf_state got=%b/%h/%0d/%b exp=1/01/3/1000", m_valid, m_data, m_port, ovf_sticky);
            failures++;
        end
        checks++;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== 8'h01) begin
                $display("FAIL ovf_stable_%0d got=%b/%h exp=1/01", n, m_valid, m_data);
                failures++;
            end
            checks++;
        end
        m_ready = 1'b1;
        tick();
        if (m_valid !== 1'b1 || m_data !== 8'h02 || m_port !== 2'd3) begin
            $display("FAIL ovf_second got=%b/%h/%0d exp=1/02/3", m_valid, m_data, m_port);
            failures++;
        end
        checks++;
        tick();
        tick();
        if (m_valid !== 1'b0 || ovf_sticky !== 4'b1000) begin
            $display("FAIL ovf_drained got=%b/%b exp=0/1000", m_valid, ovf_sticky);
            failures++;
        end
        checks++;
    endtask

`ifdef ROUTER_DESER_STATS_EN
    task automatic test_stats();
        do_reset();
        m_ready = 1'b1;
        for (int n = 0; n < 300; n++) send_words(4'b0001, {8'h00, 8'h00, 8'h00, 8'(n)});
        tick();
        tick();
        if (stat_words[15:0] !== 16'd300 || stat_words[63:16] !== 48'd0) begin
            $display("FAIL stats_count got=%h exp=%h", stat_words, 64'd300);
            failures++;
        end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_fragment();
        test_round_robin();
        test_drain_and_load();
        test_back_to_back_overflow();
`ifdef ROUTER_DESER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_out_deser.md
Name: router_out_deser

Overview:
- Downstream consumer of the 4-port serial router outputs (`o_valid[3:0]` / `o_data[3:0]`).
- Per port, shifts serial bits (LSB first) into DATA_W-bit words and flags frames that end mid-word as fragments.
- Merges completed words from all ports into one registered valid/ready stream, tagged with the source port, using round-robin arbitration.
- Feeds the checker/scoreboard-side RTL sink and gives the monitor_out path a word-level view.

Parameters:
- N_PORTS, 4, number of serial router output ports.
- DATA_W, 8, bits per assembled word.
- PORT_W, 2, width of the port tag; must equal clog2(N_PORTS).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_valid  input  N_PORTS  per-port serial valid (router `o_valid`).
- rx_data  input  N_PORTS  per-port serial data bit (router `o_data`).
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word when m_valid && m_ready at posedge.
- m_data  output  DATA_W  assembled word; bit 0 = first serial bit received.
- m_port  output  PORT_W  source port of m_data.
- frag_err  output  N_PORTS  one-cycle pulse: a frame ended with a partial word.
- ovf_sticky  output  N_PORTS  sticky: a completed word was dropped because the holding register was full.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears every output and all internal state:
  - m_valid=0, m_data=0, m_port=0, frag_err=0, ovf_sticky=0.
  - All bit counters=0, holding registers empty, RR pointer=0.
- Per-port assembler:
  - Shift register sreg plus bit counter cnt (0..DATA_W-1).
  - At posedge with rx_valid[i]=1: sreg[cnt]<=rx_data[i]; cnt<=cnt+1.
  - When cnt==DATA_W-1 the word is complete: cnt wraps to 0 and the word is written to hold[i] (hold_full[i]<=1).
- Fragment detection:
  - rx_valid[i]=0 with cnt!=0 at posedge: cnt<=0, partial word discarded, frag_err[i]=1 for exactly one cycle.
  - rx_valid[i]=0 with cnt==0: idle, no action.
- Overflow:
  - If the word completes while hold_full[i]=1 and hold[i] is not being drained that same cycle, the new word is dropped and ovf_sticky[i]<=1.
  - ovf_sticky clears only on reset.
- Simultaneous drain and complete on the same port in the same cycle: the drained word leaves, the new word loads, and hold_full stays 1. No overflow.
- Arbiter / output stage:
  - The output register is loadable when m_valid=0 or (m_valid && m_ready).
  - When loadable, pick the first port with hold_full=1, searching from rr_ptr upward and wrapping at N_PORTS-1→0.
  - On a pick: load m_data/m_port, set m_valid, clear that hold_full, and set rr_ptr<=picked+1 (mod N_PORTS).
  - When loadable and no port is full: m_valid<=0. rr_ptr is unchanged.
  - While m_valid && !m_ready: m_data and m_port are held stable and no hold register is drained.
- Latency:
  - Final bit sampled at edge k → hold_full after k.
  - If the output is loadable at k+1, m_valid is high after edge k+1, i.e. 2 cycles from final bit to m_valid.
  - Sustained throughput: 1 word/cycle aggregate.
- Reset asserted mid-word or mid-stall: all partial and held data is lost with no frag_err pulse; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro ROUTER_DESER_STATS_EN.
- Defined:
  - Adds output stat_words [N_PORTS*16-1:0], one 16-bit count per port in slice i*16 +: 16.
  - Each count increments when a word from port i is accepted (m_valid && m_ready && m_port==i).
  - Counts saturate at 16'hFFFF and reset to 0.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream: port 0 sends 5 bits, reset_n pulses low → all outputs 0, no frag_err; next full word 8'h3C on port 0 emerges as m_data=8'h3C, m_port=0.
- Single word: port 2 sends 8'hA5 LSB-first with m_ready=1 → m_valid high exactly 2 cycles after the last bit, m_data=8'hA5, m_port=2, for one cycle.
- Fragment: port 1 sends 3 bits then drops rx_valid → frag_err=4'b0010 for one cycle, no m_valid; next word 8'h0F on port 1 arrives intact.
- Round-robin: all 4 ports complete 8'h10, 8'h11, 8'h12, 8'h13 on the same edge, m_ready=1 → m_port sequence 0,1,2,3 on consecutive cycles; a second batch starts from rr_ptr.
- Back-pressure and overflow: m_ready=0, port 3 sends three words 8'h01, 8'h02, 8'h03 back-to-back → 8'h01 is in the output register, 8'h02 is in hold, 8'h03 is dropped and ovf_sticky=4'b1000. Releasing m_ready yields exactly 8'h01 then 8'h02, with m_data stable during the stall.
- Stats (ROUTER_DESER_STATS_EN): 300 words accepted on port 0 → stat_words[15:0]=300, other counts 0.
